// File: rtl/looping_recorder.sv
// Looping take recorder: captures signed samples into block RAM, plays them back once or
// in a loop, and can overdub new input onto an existing take with saturating mix.
module looping_recorder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8192,
    parameter int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    record_in,
    input  logic                    overdub_in,
    input  logic                    loop_in,
    input  logic                    audio_valid_in,
    input  logic signed [WIDTH-1:0] audio_in,
    output logic signed [WIDTH-1:0] single_out,
    output logic                    out_valid,
    output logic [LEN_W-1:0]        recording_length,
    output logic                    full,
    output logic                    finish
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, RECORD, OVERDUB, DRAIN, PLAY, DONE} state_t;

    state_t                  state;
    logic                    record_prev;
    logic [ADDR_W-1:0]       ptr;
    logic                    drain_cnt;

    logic [WIDTH-1:0]        mem [DEPTH];
    logic signed [WIDTH-1:0] rd_data;

    // Overdub pipeline: s1 waits on the RAM read, s2 holds the pending write, s3 the value just written
    logic                    s1_valid;
    logic [ADDR_W-1:0]       s1_addr;
    logic signed [WIDTH-1:0] s1_sample;
    logic                    s2_valid;
    logic [ADDR_W-1:0]       s2_addr;
    logic signed [WIDTH-1:0] s2_sum;
    logic                    s3_valid;
    logic [ADDR_W-1:0]       s3_addr;
    logic signed [WIDTH-1:0] s3_data;

    logic                    p1_valid;
    logic                    p1_last;

    logic                    rec_rise;
    logic                    rec_fall;
    logic                    go_overdub;
    logic                    at_end;
    logic                    not_full;
    logic                    rec_we;
    logic                    ov_we;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic signed [WIDTH-1:0] wr_data;
    logic                    play_issue;
    logic                    ov_issue;
    logic signed [WIDTH-1:0] stored;
    logic signed [WIDTH:0]   sum_wide;
    logic signed [WIDTH-1:0] mixed;

    assign rec_rise   = record_in & ~record_prev;
    assign rec_fall   = ~record_in & record_prev;
    assign go_overdub = overdub_in && (recording_length != '0);
    assign at_end     = ({1'b0, ptr} == (recording_length - LEN_W'(1)));
    assign not_full   = (recording_length != LEN_W'(DEPTH));

    assign play_issue = audio_valid_in && !rec_rise && !rec_fall && (state == PLAY);
    assign ov_issue   = audio_valid_in && !rec_rise && !rec_fall && (state == OVERDUB);

    // A rising edge with a strobe starts a fresh take at address 0 in the same cycle
    assign rec_we  = rst_in && audio_valid_in &&
                     (rec_rise ? !go_overdub : (!rec_fall && (state == RECORD) && not_full));
    assign ov_we   = rst_in && s2_valid && !rec_we;
    assign wr_en   = rec_we || ov_we;
    assign wr_addr = rec_we ? (rec_rise ? '0 : ptr) : s2_addr;
    assign wr_data = rec_we ? audio_in : s2_sum;

    // Bypass writes the RAM read missed so back-to-back overdubs on short takes accumulate
    always_comb begin
        stored = rd_data;
        if (s2_valid && (s2_addr == s1_addr)) begin
            stored = s2_sum;
        end else if (s3_valid && (s3_addr == s1_addr)) begin
            stored = s3_data;
        end
    end

    assign sum_wide = (WIDTH+1)'(stored) + (WIDTH+1)'(s1_sample);
    assign mixed    = (sum_wide[WIDTH] != sum_wide[WIDTH-1])
                    ? (sum_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                    : sum_wide[WIDTH-1:0];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[ptr];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            record_prev      <= 1'b0;
            ptr              <= '0;
            drain_cnt        <= 1'b0;
            single_out       <= '0;
            out_valid        <= 1'b0;
            recording_length <= '0;
            full             <= 1'b0;
            finish           <= 1'b0;
            s1_valid         <= 1'b0;
            s2_valid         <= 1'b0;
            s3_valid         <= 1'b0;
            p1_valid         <= 1'b0;
            p1_last          <= 1'b0;
        end else begin
            record_prev <= record_in;

            s1_valid  <= ov_issue;
            s1_addr   <= ptr;
            s1_sample <= audio_in;
            s2_valid  <= s1_valid;
            s2_addr   <= s1_addr;
            s2_sum    <= mixed;
            s3_valid  <= ov_we;
            s3_addr   <= s2_addr;
            s3_data   <= s2_sum;

            p1_valid  <= play_issue;
            p1_last   <= play_issue && at_end && !loop_in;
            out_valid <= p1_valid;
            if (p1_valid) begin
                single_out <= rd_data;
                if (p1_last) begin
                    finish <= 1'b1;
                end
            end

            if (rec_rise) begin
                finish <= 1'b0;
                ptr    <= '0;
                if (go_overdub) begin
                    state <= OVERDUB;
                end else begin
                    state            <= RECORD;
                    full             <= 1'b0;
                    recording_length <= audio_valid_in ? LEN_W'(1) : '0;
                    ptr              <= audio_valid_in ? ADDR_W'(1) : '0;
                end
            end else if (rec_fall) begin
                state     <= DRAIN;
                drain_cnt <= 1'b0;
            end else begin
                case (state)
                    RECORD: begin
                        if (audio_valid_in && not_full) begin
                            ptr              <= ptr + ADDR_W'(1);
                            recording_length <= recording_length + LEN_W'(1);
                            if (recording_length == LEN_W'(DEPTH - 1)) begin
                                full <= 1'b1;
                            end
                        end
                    end
                    OVERDUB: begin
                        if (audio_valid_in) begin
                            ptr <= at_end ? '0 : ptr + ADDR_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt) begin
                            ptr <= '0;
                            if (recording_length == '0) begin
                                state  <= DONE;
                                finish <= 1'b1;
                            end else begin
                                state <= PLAY;
                            end
                        end else begin
                            drain_cnt <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (audio_valid_in) begin
                            if (at_end) begin
                                ptr <= '0;
                                if (!loop_in) begin
                                    state <= DONE;
                                end
                            end else begin
                                ptr <= ptr + ADDR_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_looping_recorder.sv
// Scoreboard bench for looping_recorder: a take-level reference model predicts every playback
// sample, and a monitor process checks each out_valid pulse against the predicted queue.
module tb_looping_recorder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int LEN_W = $clog2(DEPTH) + 1;

    logic                    clk_in;
    logic                    rst_in;
    logic                    record_in;
    logic                    overdub_in;
    logic                    loop_in;
    logic                    audio_valid_in;
    logic signed [WIDTH-1:0] audio_in;
    logic signed [WIDTH-1:0] single_out;
    logic                    out_valid;
    logic [LEN_W-1:0]        recording_length;
    logic                    full;
    logic                    finish;

    looping_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .record_in        (record_in),
        .overdub_in       (overdub_in),
        .loop_in          (loop_in),
        .audio_valid_in   (audio_valid_in),
        .audio_in         (audio_in),
        .single_out       (single_out),
        .out_valid        (out_valid),
        .recording_length (recording_length),
        .full             (full),
        .finish           (finish)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int data;
        bit last;
        int cyc;
    } exp_t;

    typedef enum {M_IDLE, M_REC, M_OVD, M_PLAY, M_DONE} mode_t;

    exp_t  exp_q[$];
    int    stim[$];
    mode_t mode;
    int    take_mem[DEPTH];
    int    take_len;
    int    pos;
    bit    exp_finish;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int junk();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic rec, input logic vld, input int smp, input logic lp);
        @(posedge clk_in);
        #1;
        record_in      = rec;
        audio_valid_in = vld;
        audio_in       = WIDTH'(smp);
        loop_in        = lp;
    endtask

    task automatic model_sample(input int s);
        if (mode == M_REC) begin
            if (take_len < DEPTH) begin
                take_mem[take_len] = s;
                take_len++;
            end
        end else if (mode == M_OVD) begin
            take_mem[pos] = sat(take_mem[pos] + s);
            pos = (pos + 1) % take_len;
        end
    endtask

    task automatic model_play(input bit lp);
        exp_t e;
        if (mode == M_PLAY) begin
            e.data = take_mem[pos];
            e.last = (pos == take_len - 1) && !lp;
            e.cyc  = cyc;
            exp_q.push_back(e);
            if (pos == take_len - 1) begin
                if (lp) begin
                    pos = 0;
                end else begin
                    mode       = M_DONE;
                    exp_finish = 1'b1;
                end
            end else begin
                pos++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        rst_in         = 1'b0;
        record_in      = 1'b0;
        audio_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        exp_q.delete();
        mode       = M_IDLE;
        take_len   = 0;
        pos        = 0;
        exp_finish = 1'b0;
        checkOutput("reset_single_out", int'(single_out), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_recording_length", int'(recording_length), 0);
        checkOutput("reset_full", int'(full), 0);
        checkOutput("reset_finish", int'(finish), 0);
    endtask

    // Records (or overdubs) the samples queued in stim, then drops record_in and waits out the drain
    task automatic take(input bit ovd, input int maxgap, input bit rise_strobe);
        int first;
        int s;
        first      = 0;
        overdub_in = ovd;
        exp_finish = 1'b0;
        pos        = 0;
        if (ovd && take_len > 0) begin
            mode = M_OVD;
        end else begin
            mode     = M_REC;
            take_len = 0;
        end
        if (rise_strobe) begin
            s = (stim.size() > 0) ? stim[0] : junk();
            applyStimulus(1'b1, 1'b1, s, 1'b0);
            if (mode == M_REC) begin
                model_sample(s);
                if (stim.size() > 0) first = 1;
            end
        end else begin
            applyStimulus(1'b1, 1'b0, 0, 1'b0);
        end
        for (int i = first; i < stim.size(); i++) begin
            repeat ($urandom_range(0, maxgap)) applyStimulus(1'b1, 1'b0, 0, 1'b0);
            applyStimulus(1'b1, 1'b1, stim[i], 1'b0);
            model_sample(stim[i]);
        end
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), junk(), 1'b0);
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), junk(), 1'b0);
        checkOutput("finish_during_drain", int'(finish), 0);
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), junk(), 1'b0);
        if (take_len == 0) begin
            mode       = M_DONE;
            exp_finish = 1'b1;
        end else begin
            mode = M_PLAY;
        end
        pos = 0;
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("recording_length", int'(recording_length), take_len);
        checkOutput("full", int'(full), (take_len == DEPTH) ? 1 : 0);
        checkOutput("finish_after_drain", int'(finish), int'(exp_finish));
        stim.delete();
    endtask

    // loop_mode 0/1 holds loop_in fixed; 2 randomises it on every strobe
    task automatic play(input int n, input int maxgap, input int loop_mode);
        logic lp;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) applyStimulus(1'b0, 1'b0, 0, 1'b0);
            lp = (loop_mode == 2) ? 1'($urandom_range(0, 1)) : (loop_mode == 1);
            applyStimulus(1'b0, 1'b1, junk(), lp);
            model_play(lp);
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("pending_outputs", exp_q.size(), 0);
        checkOutput("finish_after_play", int'(finish), int'(exp_finish));
    endtask

    // Monitor: every out_valid must match the oldest predicted sample, exactly two cycles after its strobe
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_out_valid got single_out=%0d with nothing expected",
                             int'(single_out));
                end else begin
                    e = exp_q.pop_front();
                    if (int'(single_out) != e.data || finish !== e.last || (cyc - e.cyc) != 2) begin
                        errors++;
                        $display("[TB] FAIL playback got data=%0d finish=%0b latency=%0d expected data=%0d finish=%0b latency=2",
                                 int'(single_out), finish, cyc - e.cyc, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_in         = 1'b0;
        record_in      = 1'b0;
        overdub_in     = 1'b0;
        loop_in        = 1'b0;
        audio_valid_in = 1'b0;
        audio_in       = '0;
        repeat (2) @(posedge clk_in);
        do_reset();

        $display("[TB] single take 0..9, one-shot playback with two extra strobes");
        for (int i = 0; i < 10; i++) stim.push_back(i);
        take(1'b0, 0, 1'b0);
        play(12, 0, 0);

        $display("[TB] overfilled take stops at DEPTH");
        for (int i = 0; i < 20; i++) stim.push_back(i);
        take(1'b0, 0, 1'b1);
        play(16, 0, 0);

        $display("[TB] four-sample loop");
        stim = '{1, 2, 3, 4};
        take(1'b0, 1, 1'b0);
        play(10, 1, 1);

        $display("[TB] saturating overdub");
        stim = '{100, -100, 5, 0};
        take(1'b0, 0, 1'b0);
        stim = '{100, -100, -10, 7};
        take(1'b1, 0, 1'b0);
        play(4, 0, 0);

        $display("[TB] back-to-back overdub on one- and two-sample takes");
        stim = '{10};
        take(1'b0, 0, 1'b0);
        stim = '{50, 50, 50};
        take(1'b1, 0, 1'b0);
        play(2, 0, 1);
        stim = '{1, 2};
        take(1'b0, 0, 1'b0);
        stim = '{10, 20, 30, 40, 50};
        take(1'b1, 0, 1'b1);
        play(3, 0, 0);

        $display("[TB] reset in the middle of playback");
        for (int i = 0; i < 6; i++) stim.push_back(i * 7 - 20);
        take(1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 0, 1'b0);
            model_play(1'b0);
        end
        do_reset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, junk(), 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("pending_after_reset", exp_q.size(), 0);
        checkOutput("length_after_reset", int'(recording_length), 0);

        $display("[TB] empty take goes straight to done");
        take(1'b0, 0, 1'b0);
        play(3, 0, 0);

        $display("[TB] randomised takes, overdubs and playback");
        for (int iter = 0; iter < 30; iter++) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            repeat ($urandom_range(0, 20)) stim.push_back(junk());
            take(1'b0, 2, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 12)) stim.push_back(junk());
                take(1'b1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
            play($urandom_range(1, 2 * DEPTH + 4), 2, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
